// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX, MEM/WB forwarding and EX/MEM bundle for the execute stage
//
// master: upstream/downstream pipeline side (drives ID/EX, MEM/WB, flush; sees EX/MEM, ex_stall)
// slave : ex_stage
//   flush                         squash the instruction currently in EX
//   IDEX_*                        decoded instruction held in the ID/EX register
//   MEMWB_RegWrite/rd/WriteData   writeback forwarding source
//   ex_stall                      hold PC, IF/ID and ID/EX this cycle
//   EXMEM_*                       registered results for the memory stage
interface ex_stage_if;
    logic        flush;

    logic        IDEX_Branch;
    logic        IDEX_MemRead;
    logic        IDEX_MemWrite;
    logic        IDEX_MemtoReg;
    logic        IDEX_RegWrite;
    logic        IDEX_ALUSrc;
    logic [3:0]  IDEX_ALUOp;
    logic [3:0]  IDEX_Funct;
    logic [4:0]  IDEX_rs1;
    logic [4:0]  IDEX_rs2;
    logic [4:0]  IDEX_rd;
    logic [63:0] IDEX_PC_Out;
    logic [63:0] IDEX_ReadData1;
    logic [63:0] IDEX_ReadData2;
    logic [63:0] IDEX_imm;

    logic        MEMWB_RegWrite;
    logic [4:0]  MEMWB_rd;
    logic [63:0] MEMWB_WriteData;

    logic        ex_stall;

    logic        EXMEM_Branch;
    logic        EXMEM_MemRead;
    logic        EXMEM_MemWrite;
    logic        EXMEM_MemtoReg;
    logic        EXMEM_RegWrite;
    logic        EXMEM_BranchTaken;
    logic [4:0]  EXMEM_rd;
    logic [63:0] EXMEM_ALUResult;
    logic [63:0] EXMEM_WriteData;
    logic [63:0] EXMEM_BranchTarget;

    modport master (
        output flush,
        output IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite, IDEX_ALUSrc,
        output IDEX_ALUOp, IDEX_Funct, IDEX_rs1, IDEX_rs2, IDEX_rd,
        output IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm,
        output MEMWB_RegWrite, MEMWB_rd, MEMWB_WriteData,
        input  ex_stall,
        input  EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite,
        input  EXMEM_BranchTaken, EXMEM_rd, EXMEM_ALUResult, EXMEM_WriteData, EXMEM_BranchTarget
    );

    modport slave (
        input  flush,
        input  IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite, IDEX_ALUSrc,
        input  IDEX_ALUOp, IDEX_Funct, IDEX_rs1, IDEX_rs2, IDEX_rd,
        input  IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm,
        input  MEMWB_RegWrite, MEMWB_rd, MEMWB_WriteData,
        output ex_stall,
        output EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite,
        output EXMEM_BranchTaken, EXMEM_rd, EXMEM_ALUResult, EXMEM_WriteData, EXMEM_BranchTarget
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV64 execute stage with forwarding, branch resolve, iterative MUL and EX/MEM register
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    ex_stage_if.slave: ID/EX inputs, MEM/WB forwarding, flush, ex_stall, EX/MEM outputs
// Parameter:
//   MUL_CYCLES  shift-add iterations of the multiplier (one multiplier bit per cycle)
module ex_stage #(
    parameter int MUL_CYCLES = 64
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_BRANCH = 4'b0001;
    localparam logic [3:0] OP_RTYPE  = 4'b0010;
    localparam logic [3:0] OP_ITYPE  = 4'b0011;
    localparam logic [3:0] OP_MUL    = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [63:0]      product;
    logic [63:0]      multiplicand;
    logic [63:0]      multiplier;

    logic        exmem_branch;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic        exmem_mem_to_reg;
    logic        exmem_reg_write;
    logic        exmem_branch_taken;
    logic [4:0]  exmem_rd;
    logic [63:0] exmem_alu_result;
    logic [63:0] exmem_write_data;
    logic [63:0] exmem_branch_target;

    logic [63:0] op_a;
    logic [63:0] fwd_b;
    logic [63:0] op_b;
    logic [63:0] alu_result;
    logic [63:0] branch_target;
    logic [2:0]  funct3;
    logic [5:0]  shamt;
    logic        alt;
    logic        cond;
    logic        is_mul;
    logic        stall;

    // EX/MEM wins over MEM/WB because it holds the younger write to the same register.
    always_comb begin
        op_a = bus.IDEX_ReadData1;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == bus.IDEX_rs1) begin
            op_a = exmem_alu_result;
        end else if (bus.MEMWB_RegWrite && bus.MEMWB_rd != 5'd0 && bus.MEMWB_rd == bus.IDEX_rs1) begin
            op_a = bus.MEMWB_WriteData;
        end
    end

    always_comb begin
        fwd_b = bus.IDEX_ReadData2;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == bus.IDEX_rs2) begin
            fwd_b = exmem_alu_result;
        end else if (bus.MEMWB_RegWrite && bus.MEMWB_rd != 5'd0 && bus.MEMWB_rd == bus.IDEX_rs2) begin
            fwd_b = bus.MEMWB_WriteData;
        end
    end

    assign op_b          = bus.IDEX_ALUSrc ? bus.IDEX_imm : fwd_b;
    assign funct3        = bus.IDEX_Funct[2:0];
    assign shamt         = op_b[5:0];
    assign branch_target = bus.IDEX_PC_Out + (bus.IDEX_imm << 1);

    // I-type has no subtract; funct7[5] only distinguishes srli from srai.
    assign alt = (bus.IDEX_ALUOp == OP_RTYPE) ? bus.IDEX_Funct[3]
                                              : (funct3 == 3'b101) && bus.IDEX_Funct[3];

    always_comb begin
        alu_result = 64'd0;
        case (bus.IDEX_ALUOp)
            OP_ADD:    alu_result = op_a + op_b;
            OP_BRANCH: alu_result = op_a - op_b;
            OP_RTYPE, OP_ITYPE: begin
                case ({alt, funct3})
                    4'b0000: alu_result = op_a + op_b;
                    4'b1000: alu_result = op_a - op_b;
                    4'b0001: alu_result = op_a << shamt;
                    4'b0010: alu_result = {63'd0, $signed(op_a) < $signed(op_b)};
                    4'b0011: alu_result = {63'd0, op_a < op_b};
                    4'b0100: alu_result = op_a ^ op_b;
                    4'b0101: alu_result = op_a >> shamt;
                    4'b1101: alu_result = $unsigned($signed(op_a) >>> shamt);
                    4'b0110: alu_result = op_a | op_b;
                    4'b0111: alu_result = op_a & op_b;
                    default: alu_result = 64'd0;
                endcase
            end
            default:   alu_result = 64'd0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (op_a == op_b);
            3'b001:  cond = (op_a != op_b);
            3'b100:  cond = ($signed(op_a) < $signed(op_b));
            3'b101:  cond = ($signed(op_a) >= $signed(op_b));
            3'b110:  cond = (op_a < op_b);
            3'b111:  cond = (op_a >= op_b);
            default: cond = 1'b0;
        endcase
    end

    assign is_mul = (bus.IDEX_ALUOp == OP_MUL);
    // Gated by reset so a MUL sitting in ID/EX cannot stall the front end during reset.
    assign stall  = !reset && (((state == IDLE) && is_mul && !bus.flush) || (state == BUSY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            count               <= '0;
            product             <= 64'd0;
            multiplicand        <= 64'd0;
            multiplier          <= 64'd0;
            exmem_branch        <= 1'b0;
            exmem_mem_read      <= 1'b0;
            exmem_mem_write     <= 1'b0;
            exmem_mem_to_reg    <= 1'b0;
            exmem_reg_write     <= 1'b0;
            exmem_branch_taken  <= 1'b0;
            exmem_rd            <= 5'd0;
            exmem_alu_result    <= 64'd0;
            exmem_write_data    <= 64'd0;
            exmem_branch_target <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul && !bus.flush) begin
                        state        <= BUSY;
                        multiplicand <= op_a;
                        multiplier   <= op_b;
                        product      <= 64'd0;
                        count        <= '0;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (multiplier[0]) begin
                            product <= product + multiplicand;
                        end
                        multiplicand <= multiplicand << 1;
                        multiplier   <= multiplier >> 1;
                        count        <= count + CNT_W'(1);
                        if (count == CNT_W'(MUL_CYCLES - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Bubble: control cleared, data left as it was.
            if (bus.flush || stall) begin
                exmem_branch       <= 1'b0;
                exmem_mem_read     <= 1'b0;
                exmem_mem_write    <= 1'b0;
                exmem_mem_to_reg   <= 1'b0;
                exmem_reg_write    <= 1'b0;
                exmem_branch_taken <= 1'b0;
            end else begin
                exmem_branch        <= bus.IDEX_Branch;
                exmem_mem_read      <= bus.IDEX_MemRead;
                exmem_mem_write     <= bus.IDEX_MemWrite;
                exmem_mem_to_reg    <= bus.IDEX_MemtoReg;
                exmem_reg_write     <= bus.IDEX_RegWrite;
                exmem_branch_taken  <= bus.IDEX_Branch && cond;
                exmem_rd            <= bus.IDEX_rd;
                exmem_alu_result    <= (state == DONE) ? product : alu_result;
                exmem_write_data    <= fwd_b;
                exmem_branch_target <= branch_target;
            end
        end
    end

    assign bus.ex_stall           = stall;
    assign bus.EXMEM_Branch       = exmem_branch;
    assign bus.EXMEM_MemRead      = exmem_mem_read;
    assign bus.EXMEM_MemWrite     = exmem_mem_write;
    assign bus.EXMEM_MemtoReg     = exmem_mem_to_reg;
    assign bus.EXMEM_RegWrite     = exmem_reg_write;
    assign bus.EXMEM_BranchTaken  = exmem_branch_taken;
    assign bus.EXMEM_rd           = exmem_rd;
    assign bus.EXMEM_ALUResult    = exmem_alu_result;
    assign bus.EXMEM_WriteData    = exmem_write_data;
    assign bus.EXMEM_BranchTarget = exmem_branch_target;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with a cycle-level reference model
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage #(.MUL_CYCLES(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic        flush;
        logic        br, mr, mw, m2r, rw, src;
        logic [3:0]  op, fn;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] pc, rd1, rd2, imm;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [63:0] wb_data;
    } stim_t;

    // ctl = {Branch, MemRead, MemWrite, MemtoReg, RegWrite, BranchTaken}
    typedef struct packed {
        logic        stall;
        logic        chk;
        logic [5:0]  ctl;
        logic [4:0]  rd;
        logic [63:0] res, wd, tgt;
    } exp_t;

    exp_t        q[$];
    stim_t       cur;
    exp_t        m;
    int          mul_left;
    logic [63:0] mul_prod;
    logic        last_stall;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf);
        if (m.ctl[1] && m.rd != 5'd0 && m.rd == rs) return m.res;
        if (cur.wb_rw && cur.wb_rd != 5'd0 && cur.wb_rd == rs) return cur.wb_data;
        return rf;
    endfunction

    function automatic logic lt_signed(input logic [63:0] a, input logic [63:0] b);
        if (a[63] != b[63]) return a[63];
        return a < b;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [3:0] fn,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [3:0]  f;
        int          sh;
        logic [63:0] r;
        sh = int'(b[5:0]);
        f = fn;
        r = 64'd0;
        if (op == 4'd3 && fn[2:0] != 3'b101) f[3] = 1'b0;
        if (op == 4'd0) r = a + b;
        else if (op == 4'd1) r = a - b;
        else if (op == 4'd2 || op == 4'd3) begin
            case (f)
                4'h0: r = a + b;
                4'h8: r = a - b;
                4'h1: r = a << sh;
                4'h2: r = lt_signed(a, b) ? 64'd1 : 64'd0;
                4'h3: r = (a < b) ? 64'd1 : 64'd0;
                4'h4: r = a ^ b;
                4'h5: r = a >> sh;
                4'hD: r = (a >> sh) | ({64{a[63]}} & ~(~64'd0 >> sh));
                4'h6: r = a | b;
                4'h7: r = a & b;
                default: r = 64'd0;
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return lt_signed(a, b);
            3'd5: return !lt_signed(a, b);
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive();
        bus.flush          = cur.flush;
        bus.IDEX_Branch    = cur.br;
        bus.IDEX_MemRead   = cur.mr;
        bus.IDEX_MemWrite  = cur.mw;
        bus.IDEX_MemtoReg  = cur.m2r;
        bus.IDEX_RegWrite  = cur.rw;
        bus.IDEX_ALUSrc    = cur.src;
        bus.IDEX_ALUOp     = cur.op;
        bus.IDEX_Funct     = cur.fn;
        bus.IDEX_rs1       = cur.rs1;
        bus.IDEX_rs2       = cur.rs2;
        bus.IDEX_rd        = cur.rd;
        bus.IDEX_PC_Out    = cur.pc;
        bus.IDEX_ReadData1 = cur.rd1;
        bus.IDEX_ReadData2 = cur.rd2;
        bus.IDEX_imm       = cur.imm;
        bus.MEMWB_RegWrite = cur.wb_rw;
        bus.MEMWB_rd       = cur.wb_rd;
        bus.MEMWB_WriteData = cur.wb_data;
    endtask

    // One clock of stimulus; the model predicts ex_stall for this cycle and EX/MEM after the edge.
    task automatic cycle();
        exp_t        e;
        logic [63:0] a, b, bop, res;
        logic        load;
        @(negedge clk);
        reset = 1'b0;
        drive();
        a = fwd(cur.rs1, cur.rd1);
        b = fwd(cur.rs2, cur.rd2);
        bop = cur.src ? cur.imm : b;
        res = ref_alu(cur.op, cur.fn, a, bop);
        e = '0;
        load = 1'b0;
        if (mul_left > 1) begin
            e.stall = 1'b1;
            mul_left = cur.flush ? 0 : mul_left - 1;
        end else if (mul_left == 1) begin
            mul_left = 0;
            load = !cur.flush;
            res = mul_prod;
        end else if (cur.op == 4'd4 && !cur.flush) begin
            e.stall = 1'b1;
            mul_left = 65;
            mul_prod = a * bop;
        end else begin
            load = !cur.flush;
        end
        if (load) begin
            m.ctl = {cur.br, cur.mr, cur.mw, cur.m2r, cur.rw, cur.br && ref_taken(cur.fn[2:0], a, bop)};
            m.rd  = cur.rd;
            m.res = res;
            m.wd  = b;
            m.tgt = cur.pc + (cur.imm << 1);
        end else begin
            m.ctl = 6'd0;
        end
        e.chk = load;
        e.ctl = m.ctl;
        e.rd  = m.rd;
        e.res = m.res;
        e.wd  = m.wd;
        e.tgt = m.tgt;
        q.push_back(e);
        last_stall = e.stall;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        drive();
        m = '0;
        mul_left = 0;
        e = '0;
        e.chk = 1'b1;
        q.push_back(e);
        last_stall = 1'b0;
    endtask

    function automatic logic [63:0] rand64();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 20));
        return {$urandom, $urandom};
    endfunction

    task automatic rand_wb();
        cur.wb_rw   = 1'($urandom_range(0, 1));
        cur.wb_rd   = 5'($urandom_range(0, 3));
        cur.wb_data = rand64();
    endtask

    task automatic issue(input int busy_flush_pct);
        cycle();
        while (last_stall && !cur.flush) begin
            rand_wb();
            cur.flush = ($urandom_range(0, 99) < busy_flush_pct);
            cycle();
        end
        cur.flush = 1'b0;
    endtask

    task automatic rand_instr();
        logic [3:0] rfn[10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) cur.op = 4'd0;
        else if (r < 30) cur.op = 4'd1;
        else if (r < 60) cur.op = 4'd2;
        else if (r < 85) cur.op = 4'd3;
        else if (r < 89) cur.op = 4'd4;
        else cur.op = 4'($urandom_range(5, 15));
        cur.fn  = (cur.op == 4'd2) ? rfn[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
        cur.src = (cur.op == 4'd1 || cur.op == 4'd2) ? 1'b0 : 1'($urandom_range(0, 1));
        {cur.br, cur.mr, cur.mw, cur.m2r, cur.rw} = 5'($urandom_range(0, 31));
        cur.rs1 = 5'($urandom_range(0, 3));
        cur.rs2 = 5'($urandom_range(0, 3));
        cur.rd  = 5'($urandom_range(0, 3));
        cur.pc  = rand64();
        cur.rd1 = rand64();
        cur.rd2 = rand64();
        cur.imm = rand64();
        cur.flush = ($urandom_range(0, 99) < 6);
        rand_wb();
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [3:0] fn, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [63:0] d1, input logic [63:0] d2);
        cur = '0;
        cur.op = op;
        cur.fn = fn;
        cur.rs1 = rs1;
        cur.rs2 = rs2;
        cur.rd = rd;
        cur.rd1 = d1;
        cur.rd2 = d2;
        cur.rw = (op != 4'd1);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: stall sampled late in the low phase, EX/MEM sampled just after the edge.
    initial begin
        exp_t e;
        logic s;
        forever begin
            @(negedge clk);
            #3;
            s = bus.ex_stall;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_stall", 64'(s), 64'(e.stall));
                chk("exmem_ctl", 64'({bus.EXMEM_Branch, bus.EXMEM_MemRead, bus.EXMEM_MemWrite,
                                      bus.EXMEM_MemtoReg, bus.EXMEM_RegWrite, bus.EXMEM_BranchTaken}),
                    64'(e.ctl));
                if (e.chk) begin
                    chk("exmem_rd", 64'(bus.EXMEM_rd), 64'(e.rd));
                    chk("alu_result", bus.EXMEM_ALUResult, e.res);
                    chk("write_data", bus.EXMEM_WriteData, e.wd);
                    chk("branch_target", bus.EXMEM_BranchTarget, e.tgt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '0;
        m = '0;
        mul_left = 0;
        mul_prod = 64'd0;
        last_stall = 1'b0;
        do_reset();
        do_reset();

        set_alu(4'd2, 4'h0, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7);
        issue(0);
        set_alu(4'd2, 4'h8, 5'd6, 5'd7, 5'd8, 64'd5, 64'd7);
        issue(0);

        set_alu(4'd2, 4'h0, 5'd5, 5'd6, 5'd1, 64'd10, 64'd20);
        issue(0);
        set_alu(4'd2, 4'h0, 5'd1, 5'd1, 5'd4, 64'd0, 64'd0);
        issue(0);
        set_alu(4'd2, 4'h0, 5'd4, 5'd4, 5'd5, 64'd0, 64'd0);
        cur.wb_rw = 1'b1;
        cur.wb_rd = 5'd4;
        cur.wb_data = 64'd999;
        issue(0);
        set_alu(4'd2, 4'h0, 5'd9, 5'd9, 5'd0, 64'd3, 64'd3);
        issue(0);
        set_alu(4'd2, 4'h0, 5'd0, 5'd0, 5'd10, 64'd7, 64'd7);
        cur.wb_rw = 1'b1;
        cur.wb_rd = 5'd0;
        cur.wb_data = 64'd55;
        issue(0);

        set_alu(4'd1, 4'h4, 5'd11, 5'd12, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        cur.br = 1'b1;
        cur.pc = 64'h100;
        cur.imm = 64'd8;
        issue(0);
        cur.fn = 4'h6;
        issue(0);

        set_alu(4'd4, 4'h0, 5'd13, 5'd14, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        issue(0);
        set_alu(4'd4, 4'h0, 5'd13, 5'd14, 5'd8, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        issue(0);

        set_alu(4'd4, 4'h0, 5'd13, 5'd14, 5'd9, 64'd6, 64'd7);
        cycle();
        repeat (9) cycle();
        cur.flush = 1'b1;
        cycle();
        set_alu(4'd2, 4'h0, 5'd15, 5'd16, 5'd2, 64'd1, 64'd1);
        issue(0);

        set_alu(4'd4, 4'h0, 5'd13, 5'd14, 5'd9, 64'd6, 64'd7);
        cycle();
        repeat (20) cycle();
        do_reset();
        set_alu(4'd2, 4'h0, 5'd1, 5'd2, 5'd3, 64'd40, 64'd2);
        issue(0);

        for (int i = 0; i < 400; i++) begin
            rand_instr();
            issue(2);
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register for the 64-bit RISC-V pipeline, sitting directly downstream of the ID/EX register. It applies operand forwarding from the EX/MEM and MEM/WB stages, computes ALU results, and resolves conditional branches. It also runs an iterative 64-bit multiplier that stalls the front of the pipeline. All results are registered into EX/MEM outputs consumed by the memory stage.

## Interface
- MUL_CYCLES, 64: multiplier iterations (one bit per cycle).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  squash current EX instruction (from branch/hazard control).
- IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite, IDEX_ALUSrc  in  1 each  control from ID/EX.
- IDEX_ALUOp  in  4  operation class (see Operation).
- IDEX_Funct  in  4  {funct7[5], funct3}.
- IDEX_rs1, IDEX_rs2, IDEX_rd  in  5 each  register indices.
- IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm  in  64 each  PC, register operands, sign-extended immediate field.
- MEMWB_RegWrite  in  1; MEMWB_rd  in  5; MEMWB_WriteData  in  64  writeback forwarding source.
- ex_stall  out  1  hold PC, IF/ID and ID/EX this cycle (combinational).
- EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite, EXMEM_BranchTaken  out  1 each  registered.
- EXMEM_rd  out  5; EXMEM_ALUResult, EXMEM_WriteData, EXMEM_BranchTarget  out  64  registered.

## Operation
- Forwarding per operand: A = EX/MEM ALUResult if EXMEM_RegWrite && EXMEM_rd!=0 && EXMEM_rd==rs; else MEMWB_WriteData if MEMWB_RegWrite && MEMWB_rd!=0 && MEMWB_rd==rs; else ReadData. EX/MEM has priority. Load-use separation is guaranteed upstream (bubble inserted), so EX/MEM forwarding never supplies a load address.
- Operand B to ALU = IDEX_ALUSrc ? IDEX_imm : forwarded rs2. EXMEM_WriteData = forwarded rs2 (store data) regardless of ALUSrc.
- ALUOp 0000: ADD (load/store address).
- ALUOp 0001: branch. ALUResult = A-B. Taken per Funct[2:0]: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned; other codes not taken.
- ALUOp 0010 (R-type), by Funct: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- ALUOp 0011 (I-type): same table, but Funct[3] is ignored except on 101 (srli/srai).
- Shift amount = B[5:0]; slt/sltu produce 64'd0/64'd1.
- ALUOp 0100: MUL, low 64 bits of A*B, wrap modulo 2^64.
- Undefined ALUOp: result 0.
- BranchTarget = IDEX_PC_Out + (IDEX_imm << 1), modulo 2^64. EXMEM_BranchTaken = IDEX_Branch && condition.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when ALUOp==0100 and !flush; captures forwarded A, B, clears product and counter.
  - BUSY: each cycle, if multiplier bit0, product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++. After MUL_CYCLES iterations go to DONE.
  - DONE→IDLE unconditionally; EX/MEM captures the product as ALUResult this edge.
  - flush in BUSY or DONE → IDLE, no result.
- ex_stall = (IDLE && ALUOp==0100 && !flush) || BUSY.
- While ex_stall=1, EX/MEM loads a bubble (all control outputs 0; data don't-care but held).
- flush=1: EX/MEM loads a bubble; flush overrides stall.

## Timing
- Reset: all EXMEM_* outputs 0, FSM IDLE, counter 0, product 0, ex_stall 0 while reset asserted.
- Non-MUL ops: 1-cycle latency; ID/EX contents appear on EXMEM_* at the next edge.
- MUL: 1 IDLE cycle + MUL_CYCLES BUSY + 1 DONE = 66 cycles in EX; result valid on EXMEM_ALUResult after the DONE edge; ex_stall high for 65 cycles.
- Back-to-back MULs: second starts IDLE→BUSY the cycle after DONE, no gap beyond the above.
- Reset mid-multiply: immediate return to IDLE, no partial result emitted.

## Test plan
- Reset mid-operation: assert reset during BUSY -> all EXMEM_* 0, ex_stall 0, and the next ADD completes in 1 cycle.
- ADD x3=x1+x2 with ReadData1=5, ReadData2=7 -> EXMEM_ALUResult=12, EXMEM_rd=3, EXMEM_RegWrite=1 one cycle later. SUB 5-7 -> 0xFFFFFFFFFFFFFFFE.
- Forwarding: back-to-back add x1 then add x4=x1+x1 with stale ReadData=0 -> EX/MEM forwarding gives 2×result. Same rd in both EX/MEM and MEM/WB -> EX/MEM value used. rd=0 is never forwarded.
- Branch: BLT A=-1, B=1, PC=0x100, imm=8 -> BranchTaken=1, BranchTarget=0x110. BLTU with the same operands -> BranchTaken=0.
- MUL 0xFFFFFFFFFFFFFFFF×3 -> result 0xFFFFFFFFFFFFFFFD after 66 cycles; ex_stall high exactly 65 cycles; EX/MEM control bits 0 during the stall.
- flush at BUSY cycle 10 -> FSM IDLE next cycle, ex_stall 0, EX/MEM bubble, and no product is ever written.
